// File: rtl/ysyx_23060061_core_ctrl_pkg.sv
// rtl/ysyx_23060061_core_ctrl_pkg.sv - shared state, halt-code and control-latch types for the core sequencer
package ysyx_23060061_core_ctrl_pkg;

    localparam int STALL_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_IF_REQ   = 4'd1,
        ST_IF_WAIT  = 4'd2,
        ST_ID       = 4'd3,
        ST_EX       = 4'd4,
        ST_MEM_REQ  = 4'd5,
        ST_MEM_WAIT = 4'd6,
        ST_WB       = 4'd7,
        ST_HALT     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_EBREAK  = 2'b01,
        HALT_TIMEOUT = 2'b10,
        HALT_BUS_ERR = 2'b11
    } halt_code_e;

    // Decoder bits captured once per instruction in ID.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic ebreak;
    } ctrl_t;

endpackage

// File: rtl/ysyx_23060061_core_ctrl_stall_timer.sv
// rtl/ysyx_23060061_core_ctrl_stall_timer.sv - bus-stall watchdog counter
// Ports: clk, rst_n (async active-low); clear restarts the count; stall counts
// one waiting cycle; expire flags the stall cycle that brings the count to TIMEOUT.
module ysyx_23060061_StallTimer
    import ysyx_23060061_core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic stall,
    output logic expire
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(TIMEOUT - 1);

    logic [STALL_W-1:0] cnt_q, cnt_d;

    // Expiry is qualified by stall, so a handshake in the expiry cycle wins.
    assign expire = stall && (cnt_q >= LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {STALL_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_23060061_core_ctrl.sv
// rtl/ysyx_23060061_core_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
// Ports: clk, rst_n (async active-low); IFU req/resp handshake; decoder control
// bits (sampled in ID only); LSU req/resp handshake; rf_we/pc_we/inst_we
// strobes; halt, halt_code and the retired-instruction counter. All outputs are
// decoded from registered state only.
module ysyx_23060061_core_ctrl
    import ysyx_23060061_core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int RET_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_resp_valid,
    input  logic             ifu_resp_err,
    output logic             inst_we,
    input  logic             dec_reg_write,
    input  logic             dec_mem_write,
    input  logic             dec_mem_read,
    input  logic             dec_ebreak,
    output logic             lsu_req_valid,
    output logic             lsu_req_wen,
    input  logic             lsu_req_ready,
    input  logic             lsu_resp_valid,
    input  logic             lsu_resp_err,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [RET_W-1:0] retired
);

    state_e           state_q, state_d;
    halt_code_e       halt_code_q, halt_code_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             inst_we_q, inst_we_d;

    logic stall, timer_clear, expire;

    // A cycle spent in a request/wait state without its handshake.
    assign stall = ((state_q == ST_IF_REQ)   && !ifu_req_ready)  ||
                   ((state_q == ST_IF_WAIT)  && !ifu_resp_valid) ||
                   ((state_q == ST_MEM_REQ)  && !lsu_req_ready)  ||
                   ((state_q == ST_MEM_WAIT) && !lsu_resp_valid);

    // Restarting on every state change gives each wait state a fresh budget.
    assign timer_clear = (state_d != state_q);

    ysyx_23060061_StallTimer #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .stall (stall),
        .expire(expire)
    );

    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        ctrl_d      = ctrl_q;
        retired_d   = retired_q;
        inst_we_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_IF_REQ;
            ST_IF_REQ: begin
                if (ifu_req_ready) begin
                    state_d = ST_IF_WAIT;
                end else if (expire) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            ST_IF_WAIT: begin
                if (ifu_resp_valid) begin
                    if (ifu_resp_err) begin
                        state_d     = ST_HALT;
                        halt_code_d = HALT_BUS_ERR;
                    end else begin
                        // Registered, so the capture strobe is seen during ID.
                        inst_we_d = 1'b1;
                        state_d   = ST_ID;
                    end
                end else if (expire) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            ST_ID: begin
                ctrl_d  = '{reg_write: dec_reg_write, mem_write: dec_mem_write,
                            mem_read: dec_mem_read, ebreak: dec_ebreak};
                state_d = ST_EX;
            end
            ST_EX: begin
                if (ctrl_q.ebreak) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_EBREAK;
                end else if (ctrl_q.mem_read || ctrl_q.mem_write) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end else if (expire) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            ST_MEM_WAIT: begin
                if (lsu_resp_valid) begin
                    if (lsu_resp_err) begin
                        state_d     = ST_HALT;
                        halt_code_d = HALT_BUS_ERR;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expire) begin
                    state_d     = ST_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            ST_WB: begin
                retired_d = retired_q + RET_W'(1);
                state_d   = ST_IF_REQ;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            halt_code_q <= HALT_NONE;
            ctrl_q      <= '0;
            retired_q   <= '0;
            inst_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
            ctrl_q      <= ctrl_d;
            retired_q   <= retired_d;
            inst_we_q   <= inst_we_d;
        end
    end

    assign ifu_req_valid = (state_q == ST_IF_REQ);
    assign lsu_req_valid = (state_q == ST_MEM_REQ);
    assign lsu_req_wen   = (state_q == ST_MEM_REQ) && ctrl_q.mem_write;
    // Stores never write the register file, whatever the decoder said.
    assign rf_we         = (state_q == ST_WB) && ctrl_q.reg_write && !ctrl_q.mem_write;
    assign pc_we         = (state_q == ST_WB);
    assign inst_we       = inst_we_q;
    assign halt          = (state_q == ST_HALT);
    assign halt_code     = halt_code_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_ysyx_23060061_core_ctrl.sv
// tb/tb_ysyx_23060061_core_ctrl.sv - self-checking bench for ysyx_23060061_core_ctrl
module tb_ysyx_23060061_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_ready = 0, ifu_resp_valid = 0, ifu_resp_err = 0;
    logic        dec_reg_write = 0, dec_mem_write = 0, dec_mem_read = 0, dec_ebreak = 0;
    logic        lsu_req_ready = 0, lsu_resp_valid = 0, lsu_resp_err = 0;
    logic        ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we, halt;
    logic [1:0]  halt_code;
    logic [63:0] retired;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint unsigned model_ret = 0;

    always #5 clk = ~clk;

    ysyx_23060061_core_ctrl #(.TIMEOUT(8), .RET_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err),
        .inst_we(inst_we),
        .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
        .dec_mem_read(dec_mem_read), .dec_ebreak(dec_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
        .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_err(lsu_resp_err),
        .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .halt_code(halt_code),
        .retired(retired)
    );

    task automatic zero_in();
        ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_err = 0;
        lsu_req_ready = 0; lsu_resp_valid = 0; lsu_resp_err = 0;
    endtask

    // Resets and leaves the bench at the falling edge inside the first IF_REQ cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        zero_in();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        model_ret = 0;
    endtask

    // Bus responder for one instruction. Entered at a falling edge inside IF_REQ.
    // sr/sp/lr/lp = cycles withheld before req-ready / response (fetch, then data).
    // Returns after the WB cycle (bench then sits in the next IF_REQ) or on halt.
    task automatic run_instr(input bit rw, mw, mrd, eb, if_err, mem_err,
                             input int sr, sp, lr, lp, abort_k,
                             output int cyc, ni, nr, np, nl, nw,
                             output bit halted, aborted);
        int phase = 0;
        int k = 0;
        cyc = 0; ni = 0; nr = 0; np = 0; nl = 0; nw = 0; halted = 0; aborted = 0;
        dec_reg_write = rw; dec_mem_write = mw; dec_mem_read = mrd; dec_ebreak = eb;
        while (cyc < 300) begin
            cyc++;
            ni += int'(inst_we); nr += int'(rf_we); np += int'(pc_we);
            nl += int'(lsu_req_valid); nw += int'(lsu_req_valid && lsu_req_wen);
            zero_in();
            if (halt) begin halted = 1; break; end
            if (pc_we) begin @(posedge clk); @(negedge clk); break; end
            if (phase == 0) begin
                if (k == sr) begin ifu_req_ready = 1; phase = 1; k = 0; end else k++;
            end else if (phase == 1) begin
                if (k == sp) begin ifu_resp_valid = 1; ifu_resp_err = if_err; phase = 2; end else k++;
            end else begin
                if (phase == 2 && lsu_req_valid) begin phase = 3; k = 0; end
                if (phase == 3) begin
                    if (k == lr) begin lsu_req_ready = 1; phase = 4; k = 0; end else k++;
                end else if (phase == 4) begin
                    if (abort_k >= 0 && k == abort_k) begin aborted = 1; break; end
                    if (k == lp) begin lsu_resp_valid = 1; lsu_resp_err = mem_err; phase = 5; end else k++;
                end
            end
            @(posedge clk); @(negedge clk);
        end
        zero_in();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++;
        if ({ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we, halt} !== 7'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 0", {ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rf_we, pc_we, halt});
        end
        n_cmp++;
        if (halt_code !== 2'b00 || retired !== 64'd0) begin
            n_bad++; $display("FAIL reset_regs got code=%b ret=%0d want 00/0", halt_code, retired);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++;
        if (ifu_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_first_cycle got ifu_req_valid=%b want 0", ifu_req_valid); end
        @(negedge clk);
        n_cmp++;
        if (ifu_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_second_cycle got ifu_req_valid=%b want 1", ifu_req_valid); end
        model_ret = 0;
    endtask

    task automatic test_addi();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        model_ret++;
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL addi_cycles got %0d want 5", cyc); end
        n_cmp++; if ({ni, nr, np} !== {32'd1, 32'd1, 32'd1}) begin n_bad++; $display("FAIL addi_pulses got inst=%0d rf=%0d pc=%0d want 1/1/1", ni, nr, np); end
        n_cmp++; if (retired !== model_ret) begin n_bad++; $display("FAIL addi_retired got %0d want %0d", retired, model_ret); end
    endtask

    task automatic test_store_stall();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        model_ret++;
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL store_cycles got %0d want 10", cyc); end
        n_cmp++; if (nl !== 4 || nw !== 4) begin n_bad++; $display("FAIL store_req got valid=%0d wen=%0d want 4/4", nl, nw); end
        n_cmp++; if (nr !== 0 || np !== 1) begin n_bad++; $display("FAIL store_wb got rf=%0d pc=%0d want 0/1", nr, np); end
        n_cmp++; if (retired !== model_ret) begin n_bad++; $display("FAIL store_retired got %0d want %0d", retired, model_ret); end
    endtask

    // Random ALU/load/store mix with random handshake stalls.
    task automatic test_random();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 2));
            bit rw = 1'($urandom);
            int sr = int'($urandom_range(0, 4)), sp = int'($urandom_range(0, 4));
            int lr = int'($urandom_range(0, 4)), lp = int'($urandom_range(0, 4));
            bit is_mem = (kind != 0), is_st = (kind == 2);
            int exp_cyc = 5 + sr + sp + (is_mem ? 2 + lr + lp : 0);
            int exp_nl = is_mem ? lr + 1 : 0;
            run_instr(rw, is_st, kind == 1, 0, 0, 0, sr, sp, lr, lp, -1, cyc, ni, nr, np, nl, nw, h, a);
            model_ret++;
            n_cmp++; if (cyc !== exp_cyc) begin n_bad++; $display("FAIL rand%0d_cycles got %0d want %0d", i, cyc, exp_cyc); end
            n_cmp++; if (ni !== 1 || np !== 1 || nr !== int'(rw && !is_st)) begin
                n_bad++; $display("FAIL rand%0d_pulses got inst=%0d pc=%0d rf=%0d want 1/1/%0d", i, ni, np, nr, int'(rw && !is_st)); end
            n_cmp++; if (nl !== exp_nl || nw !== (is_st ? exp_nl : 0)) begin
                n_bad++; $display("FAIL rand%0d_lsu got valid=%0d wen=%0d want %0d/%0d", i, nl, nw, exp_nl, is_st ? exp_nl : 0); end
            n_cmp++; if (retired !== model_ret || h !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_retired got %0d halt=%b want %0d/0", i, retired, h, model_ret); end
        end
    endtask

    task automatic test_reset_midflight();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        run_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 100, 2, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_memwait got %b want 1", a); end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({ifu_req_valid, inst_we, lsu_req_valid, rf_we, pc_we, halt, halt_code} !== 8'b0 || retired !== 64'd0) begin
            n_bad++; $display("FAIL midrst_outputs got ifu=%b lsu=%b halt=%b ret=%0d want all 0", ifu_req_valid, lsu_req_valid, halt, retired);
        end
        @(posedge clk); @(negedge clk);
        lsu_resp_valid = 1; lsu_resp_err = 1;
        rst_n = 1;
        #1;
        n_cmp++; if (ifu_req_valid !== 1'b0 || halt !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got ifu=%b halt=%b want 0/0", ifu_req_valid, halt); end
        @(negedge clk);
        n_cmp++; if (ifu_req_valid !== 1'b1 || halt !== 1'b0) begin n_bad++; $display("FAIL midrst_resume got ifu=%b halt=%b want 1/0", ifu_req_valid, halt); end
        zero_in();
        model_ret = 0;
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        model_ret++;
        n_cmp++; if (cyc !== 5 || retired !== model_ret) begin n_bad++; $display("FAIL midrst_next got cyc=%0d ret=%0d want 5/%0d", cyc, retired, model_ret); end
    endtask

    task automatic test_bus_err();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        run_instr(1, 0, 1, 0, 0, 1, 1, 0, 1, 1, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b1 || halt_code !== 2'b11) begin n_bad++; $display("FAIL load_err_halt got halt=%b code=%b want 1/11", h, halt_code); end
        n_cmp++; if (cyc !== 10 || nr !== 0 || np !== 0) begin n_bad++; $display("FAIL load_err_wb got cyc=%0d rf=%0d pc=%0d want 10/0/0", cyc, nr, np); end
        do_reset();
        run_instr(1, 0, 0, 0, 1, 0, 0, 2, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b1 || halt_code !== 2'b11 || cyc !== 5) begin n_bad++; $display("FAIL fetch_err got halt=%b code=%b cyc=%0d want 1/11/5", h, halt_code, cyc); end
        n_cmp++; if (ni !== 0) begin n_bad++; $display("FAIL fetch_err_inst_we got %0d want 0", ni); end
    endtask

    task automatic test_timeout();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        do_reset();
        run_instr(1, 0, 0, 0, 0, 0, 1, 1000, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        // one stalled + one accepted IF_REQ cycle, 8 IF_WAIT cycles, then HALT
        n_cmp++; if (h !== 1'b1 || halt_code !== 2'b10) begin n_bad++; $display("FAIL timeout_halt got halt=%b code=%b want 1/10", h, halt_code); end
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL timeout_latency got %0d want 11", cyc); end
        do_reset();
        run_instr(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b0 || cyc !== 12 || ni !== 1) begin n_bad++; $display("FAIL timeout_edge got halt=%b cyc=%0d inst=%0d want 0/12/1", h, cyc, ni); end
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 7, 7, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b0 || cyc !== 21) begin n_bad++; $display("FAIL timeout_mem_edge got halt=%b cyc=%0d want 0/21", h, cyc); end
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 8, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b1 || halt_code !== 2'b10 || cyc !== 13) begin n_bad++; $display("FAIL timeout_memreq got halt=%b code=%b cyc=%0d want 1/10/13", h, halt_code, cyc); end
    endtask

    task automatic test_ebreak();
        int cyc, ni, nr, np, nl, nw; bit h, a;
        int act = 0;
        do_reset();
        repeat (2) begin
            run_instr(1, 0, 0, 0, 0, 0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
            model_ret++;
        end
        run_instr(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, -1, cyc, ni, nr, np, nl, nw, h, a);
        n_cmp++; if (h !== 1'b1 || halt_code !== 2'b01) begin n_bad++; $display("FAIL ebreak_halt got halt=%b code=%b want 1/01", h, halt_code); end
        n_cmp++; if (retired !== model_ret) begin n_bad++; $display("FAIL ebreak_retired got %0d want %0d", retired, model_ret); end
        n_cmp++; if (cyc !== 5 || np !== 0 || nr !== 0) begin n_bad++; $display("FAIL ebreak_wb got cyc=%0d pc=%0d rf=%0d want 5/0/0", cyc, np, nr); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            act += int'(ifu_req_valid || lsu_req_valid || pc_we || rf_we || inst_we || !halt);
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL ebreak_quiet got %0d active cycles want 0", act); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_stall();
        test_random();
        test_reset_midflight();
        test_bus_err();
        test_timeout();
        test_ebreak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
